// File: rtl/mux_c_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux_c: drives active-low enable G and select C
// from registered state, bounds each grant under contention and inserts a one-cycle handoff gap.
module mux_c_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic       G,
  output logic [1:0] C,
  output logic [3:0] GNT,
  output logic       BUSY,
  output logic       PREEMPT
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          g_q, g_d;
  logic [1:0]    c_q, c_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;

  logic          found_s;
  logic [1:0]    win_s;

  // Returns {found, index} of the first set request at or after ptr, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign {found_s, win_s} = rr_pick(REQ, ptr_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    g_d       = g_q;
    c_d       = c_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (found_s) begin
          state_d = S_GRANT;
          c_d     = win_s;
          gnt_d   = 4'b0001 << win_s;
          g_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_IDLE;
          g_d     = 1'b1;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      S_GRANT: begin
        // Owner dropping its request takes precedence over the hold limit.
        if (!REQ[c_q]) begin
          state_d = S_RELEASE;
          ptr_d   = c_q + 2'd1;
          g_d     = 1'b1;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if ((cnt_q == HOLD_C) && ((REQ & ~gnt_q) != 4'b0000)) begin
          state_d   = S_RELEASE;
          ptr_d     = c_q + 2'd1;
          g_d       = 1'b1;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          preempt_d = 1'b1;
        end else begin
          state_d = S_GRANT;
          if (cnt_q != HOLD_C) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        g_d     = 1'b1;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      g_q       <= 1'b1;
      c_q       <= 2'd0;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      c_q       <= c_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign G       = g_q;
  assign C       = c_q;
  assign GNT     = gnt_q;
  assign BUSY    = busy_q;
  assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_mux_c_arbiter.sv
// Directed bench for mux_c_arbiter (HOLD_MAX=4): expectations queued with each stimulus step,
// popped and compared one cycle later against {G,C,GNT,BUSY,PREEMPT}.
module tb_mux_c_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic       G;
  logic [1:0] C;
  logic [3:0] GNT;
  logic       BUSY;
  logic       PREEMPT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } item_t;

  item_t sb_q[$];

  mux_c_arbiter #(.HOLD_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .G(G), .C(C),
    .GNT(GNT), .BUSY(BUSY), .PREEMPT(PREEMPT)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, queue the expected outputs, then check after the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic g,
                      input logic [1:0] c, input logic [3:0] gnt, input logic busy,
                      input logic pre, input string tag);
    item_t it;
    logic [8:0] obs;
    RST = rst;
    REQ = req;
    it.exp = {g, c, gnt, busy, pre};
    it.tag = tag;
    sb_q.push_back(it);
    @(posedge CLK);
    #1;
    obs = {G, C, GNT, BUSY, PREEMPT};
    it = sb_q.pop_front();
    total++;
    assert (obs === it.exp) else begin
      bad++;
      $error("FAIL %s: observed G,C,GNT,BUSY,PRE=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask

  initial begin
    // reset held with all requests asserted
    step(1'b1, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "reset0");
    step(1'b1, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "reset1");

    // full contention: owners 0,1,2,3 twice, 4 grant cycles + 1 preempt gap each
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        for (int h = 0; h < 4; h++) begin
          step(1'b0, 4'b1111, 1'b0, 2'(k), 4'b0001 << k, 1'b1, 1'b0, "contend_grant");
        end
        step(1'b0, 4'b1111, 1'b1, 2'(k), 4'b0000, 1'b0, 1'b1, "contend_gap");
      end
    end
    step(1'b0, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0, "idle_after_contend");

    // single requester
    step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "single_grant");
    step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "single_hold");
    step(1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "single_release");
    step(1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "single_idle");

    // no contention: grant persists past the hold limit
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "nocontend");
    end
    step(1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, "nocontend_release");

    // coincident drop: PTR=2, REQ=0011 wraps to owner 0; drop REQ[0] at the limit
    for (int h = 0; h < 4; h++) begin
      step(1'b0, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "coinc_grant");
    end
    step(1'b0, 4'b0010, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "coinc_release");
    step(1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "coinc_next");
    step(1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, "coinc_done");

    // reset mid-grant returns PTR to 0
    step(1'b0, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, "rstmid_grant");
    step(1'b1, 4'b1000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "rstmid_reset");
    step(1'b0, 4'b1010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "rstmid_ptr0");

    total++;
    assert (sb_q.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
